branch_issue_queue: RTL and testbench
=====================================

Name: branch_issue_queue

Overview:
- Reservation station and scheduler for the single branch execution unit.
- Holds up to RS_DEPTH dispatched branch/JAL/JALR ops and captures operands from the CDB.
- Each cycle, selects the oldest fully-ready entry (age relative to ROB head) and drives the branch unit's input bundle from a register stage.
- Squashes wrong-path entries on a pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register index width
- RS_DEPTH, 4, number of entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  at least one free entry
- i_disp_alu_op  in  4  {0,funct3} branch; 4'b1000 JAL; 4'b1001 JALR
- i_disp_pc / i_disp_imm  in  DATA_WIDTH  instruction PC / sign-extended immediate
- i_disp_rob_tag  in  ROB_WIDTH  ROB tag
- i_disp_prd  in  PREG_WIDTH  link destination (0 = none)
- i_disp_prs1 / i_disp_prs2  in  PREG_WIDTH  source physical registers
- i_disp_rdy1 / i_disp_rdy2  in  1  source value already available
- i_disp_op1 / i_disp_op2  in  DATA_WIDTH  source values (valid when rdy)
- i_cdb_valid  in  1  CDB broadcast
- i_cdb_prd  in  PREG_WIDTH  broadcast tag
- i_cdb_data  in  DATA_WIDTH  broadcast value
- i_rob_head  in  ROB_WIDTH  tag of oldest in-flight instruction
- i_flush  in  1  mispredict recovery
- i_flush_rob_tag  in  ROB_WIDTH  tag of mispredicting branch
- o_issue_valid  out  1  issue bundle valid (to branch unit i_valid)
- o_issue_op1 / o_issue_op2 / o_issue_pc / o_issue_imm  out  DATA_WIDTH  issued operands
- o_issue_alu_op  out  4  issued op
- o_issue_rob_tag  out  ROB_WIDTH  issued tag
- o_issue_prd  out  PREG_WIDTH  issued destination

Behaviour:
- Reset (rst_n=0 at edge): all entries invalid; every o_issue_* output = 0; o_disp_ready = 1 from the first cycle after reset. Reset mid-operation discards all entries and any pending issue.
- o_disp_ready = OR of ~valid over entries. Combinational from registered state only; does not anticipate a same-cycle issue free.
- Dispatch fires on i_disp_valid && o_disp_ready && !i_flush. It writes the lowest-index free entry.
- Same-cycle CDB forwarding into the dispatching entry is mandatory: if i_cdb_valid, i_cdb_prd == i_disp_prsN, i_cdb_prd != 0 and !i_disp_rdyN, the entry stores rdyN=1 and opN=i_cdb_data.
- Wakeup: every valid entry whose source is not ready and matches i_cdb_prd (nonzero) sets rdy and latches i_cdb_data at the edge. prs=0 is treated as ready with value 0 at dispatch.
- Age = (rob_tag - i_rob_head) mod 2^ROB_WIDTH; smaller is older.
- Select: among valid entries with rdy1 && rdy2 (using state before this edge), pick the minimum age. Tags are unique, so there are no ties.
- Issue: at the edge, the o_issue_* registers load the selected entry and that entry is freed, giving 1-cycle latency from ready to o_issue_valid. If nothing is selected, o_issue_valid <= 0 and the data outputs hold.
- The queue issues at most one op per cycle. The branch unit is combinational and always accepts, so there is no issue backpressure.
- Flush (i_flush=1): at the edge, every entry with age > age(i_flush_rob_tag) is invalidated, and dispatch is ignored.
  - Selection in a flush cycle considers only surviving entries; o_issue_valid next cycle is 0 if none survive.
  - An already-registered issue bundle is not retracted.
- Simultaneous dispatch and issue from a full queue: ready stays 0 this cycle and rises next cycle.
- Simultaneous wakeup and select of the same entry is not possible; the entry issues one cycle later.
- A ROB tag wraps modulo 2^ROB_WIDTH. RS_DEPTH must be below the ROB depth so age compare stays unambiguous.

Optional Feature:
- BRANCH_IQ_PERF_EN defined: adds outputs o_perf_issued and o_perf_squashed, each 32 bits, saturating.
  - o_perf_issued increments per issue; o_perf_squashed adds the number of entries squashed per flush.
  - Both clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package (ooo_pkg):
  - branch alu_op encodings: ALU_JAL=4'b1000, ALU_JALR=4'b1001
  - typedef struct bru_issue_t: alu_op, op1, op2, pc, imm, rob_tag, prd
  - typedef struct rs_entry_t: valid, rdy1, rdy2, prs1, prs2, bru_issue_t
- Sub-module rob_age_select: combinational oldest-ready picker. Inputs are the request vector, tags and head; outputs are grant one-hot and any.

Test Plan:
- Reset, then dispatch BEQ tag 3 with rdy1=rdy2=1, op1=op2=5 -> o_issue_valid=1 exactly one cycle later, alu_op 0, rob_tag 3; o_disp_ready stays 1.
- Dispatch tag 2 with prs1=9 not ready, then CDB prd 9 data 0x40 two cycles later -> issue the cycle after the CDB with op1=0x40.
- Head=14; dispatch ready ops tags 1, 15, 14 in the same idle window -> issue order is 14, 15, 1 (wrap-around age).
- Fill 4 entries with not-ready ops -> o_disp_ready=0 and further dispatch is held; one wakeup -> ready returns 1 the cycle after that entry issues.
- Entries tags 5, 6, 7 pending, head=4; i_flush with tag 5 plus a simultaneous dispatch tag 8 -> only tag 5 remains, tag 8 is dropped, and the next issue is tag 5.
- Dispatch with prs2=12 not ready while CDB broadcasts prd 12 data 0x7 in the same cycle -> the entry is ready on entry and issues next cycle with op2=0x7.

Source files
------------

// File: rtl/ooo_pkg.sv
// ooo_pkg: types and constants shared by the out-of-order back end.
//
// Contents:
//   XLEN / ROB_TAG_W / PREG_W  - storage widths of the issue bundle and
//                                 reservation-station entry types
//   ALU_JAL / ALU_JALR          - branch-unit op encodings beyond {0,funct3}
//   bru_issue_t                 - bundle handed to the branch execution unit
//   rs_entry_t                  - one branch reservation-station slot
package ooo_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 7;

  localparam logic [3:0] ALU_JAL  = 4'b1000;
  localparam logic [3:0] ALU_JALR = 4'b1001;

  typedef struct packed {
    logic [3:0]           alu_op;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    prd;
  } bru_issue_t;

  typedef struct packed {
    logic              valid;
    logic              rdy1;
    logic              rdy2;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    bru_issue_t        bru;
  } rs_entry_t;

endpackage

// File: rtl/rob_age_select.sv
// rob_age_select: combinational oldest-request picker.
//
// Age of a request is (tag - head) modulo 2^TAG_W, so the entry closest
// to the ROB head wins even across tag wrap-around. Tags are unique among
// requesters, so no tie-break is needed.
//
// Ports:
//   i_req    in  N        request vector
//   i_tags   in  N x TAG_W ROB tag per requester
//   i_head   in  TAG_W    ROB head tag
//   o_grant  out N        one-hot grant of the oldest requester
//   o_any    out 1        at least one request present
module rob_age_select #(
  parameter int N     = 4,
  parameter int TAG_W = 4
) (
  input  logic [N-1:0]            i_req,
  input  logic [N-1:0][TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]        i_head,
  output logic [N-1:0]            o_grant,
  output logic                    o_any
);

  logic [TAG_W-1:0] age;
  logic [TAG_W-1:0] best_age;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves a value unassigned and no latch is inferred.
    o_grant  = '0;
    o_any    = 1'b0;
    age      = '0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      age = i_tags[i] - i_head;
      if (i_req[i] && (!o_any || age < best_age)) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_any      = 1'b1;
        best_age   = age;
      end
    end
  end

endmodule

// File: rtl/branch_issue_queue.sv
// branch_issue_queue: reservation station and scheduler for the single
// branch execution unit.
//
// Holds up to RS_DEPTH dispatched branch/JAL/JALR ops, captures source
// operands from the CDB (including same-cycle forwarding at dispatch),
// picks the oldest fully-ready entry relative to the ROB head and loads it
// into a registered issue bundle. A flush squashes every entry younger
// than the mispredicting branch.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_disp_*, o_disp_ready     dispatch request and free-slot indication
//   i_cdb_valid/prd/data       result broadcast for operand wakeup
//   i_rob_head                 tag of the oldest in-flight instruction
//   i_flush, i_flush_rob_tag   mispredict recovery
//   o_issue_*                  registered bundle to the branch unit
//   o_perf_issued/squashed     saturating event counters, present only
//                              when BRANCH_IQ_PERF_EN is defined
//
// Entry storage uses the ooo_pkg types, so DATA_WIDTH / ROB_WIDTH /
// PREG_WIDTH must equal XLEN / ROB_TAG_W / PREG_W of that package.
module branch_issue_queue
  import ooo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int RS_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_disp_valid,
  output logic                  o_disp_ready,
  input  logic [3:0]            i_disp_alu_op,
  input  logic [DATA_WIDTH-1:0] i_disp_pc,
  input  logic [DATA_WIDTH-1:0] i_disp_imm,
  input  logic [ROB_WIDTH-1:0]  i_disp_rob_tag,
  input  logic [PREG_WIDTH-1:0] i_disp_prd,
  input  logic [PREG_WIDTH-1:0] i_disp_prs1,
  input  logic [PREG_WIDTH-1:0] i_disp_prs2,
  input  logic                  i_disp_rdy1,
  input  logic                  i_disp_rdy2,
  input  logic [DATA_WIDTH-1:0] i_disp_op1,
  input  logic [DATA_WIDTH-1:0] i_disp_op2,
  input  logic                  i_cdb_valid,
  input  logic [PREG_WIDTH-1:0] i_cdb_prd,
  input  logic [DATA_WIDTH-1:0] i_cdb_data,
  input  logic [ROB_WIDTH-1:0]  i_rob_head,
  input  logic                  i_flush,
  input  logic [ROB_WIDTH-1:0]  i_flush_rob_tag,
  output logic                  o_issue_valid,
  output logic [DATA_WIDTH-1:0] o_issue_op1,
  output logic [DATA_WIDTH-1:0] o_issue_op2,
  output logic [DATA_WIDTH-1:0] o_issue_pc,
  output logic [DATA_WIDTH-1:0] o_issue_imm,
  output logic [3:0]            o_issue_alu_op,
  output logic [ROB_WIDTH-1:0]  o_issue_rob_tag,
  output logic [PREG_WIDTH-1:0] o_issue_prd
`ifdef BRANCH_IQ_PERF_EN
  ,
  output logic [31:0]           o_perf_issued,
  output logic [31:0]           o_perf_squashed
`endif
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  rs_entry_t  entries_q [RS_DEPTH];
  rs_entry_t  entries_d [RS_DEPTH];
  bru_issue_t issue_q, issue_d;
  logic       issue_valid_q, issue_valid_d;

  logic [RS_DEPTH-1:0]                free_vec;
  logic [RS_DEPTH-1:0]                req_vec;
  logic [RS_DEPTH-1:0]                squash_vec;
  logic [RS_DEPTH-1:0]                grant_vec;
  logic                               grant_any;
  logic [RS_DEPTH-1:0][ROB_WIDTH-1:0] tag_vec;
  logic [ROB_WIDTH-1:0]               flush_age;
  logic [ROB_WIDTH-1:0]               entry_age;
  logic [IDX_W-1:0]                   alloc_idx;
  logic                               disp_fire;
  logic                               cdb_hit1, cdb_hit2;
  rs_entry_t                          disp_entry;

  // Per-entry status. Squashed entries are removed from selection so a
  // flush cycle can only issue a surviving op.
  always_comb begin
    free_vec   = '0;
    req_vec    = '0;
    squash_vec = '0;
    tag_vec    = '0;
    entry_age  = '0;
    flush_age  = i_flush_rob_tag - i_rob_head;
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i]   = ~entries_q[i].valid;
      tag_vec[i]    = entries_q[i].bru.rob_tag;
      entry_age     = entries_q[i].bru.rob_tag - i_rob_head;
      squash_vec[i] = i_flush && entries_q[i].valid && (entry_age > flush_age);
      req_vec[i]    = entries_q[i].valid && entries_q[i].rdy1 &&
                      entries_q[i].rdy2 && !squash_vec[i];
    end
  end

  rob_age_select #(
    .N     (RS_DEPTH),
    .TAG_W (ROB_WIDTH)
  ) u_select (
    .i_req   (req_vec),
    .i_tags  (tag_vec),
    .i_head  (i_rob_head),
    .o_grant (grant_vec),
    .o_any   (grant_any)
  );

  // Readiness reflects registered occupancy only; a slot freed by this
  // cycle's issue becomes visible next cycle.
  assign o_disp_ready = |free_vec;
  assign disp_fire    = i_disp_valid && o_disp_ready && !i_flush;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Dispatching entry. A zero source register is the constant-zero
  // register and is ready on arrival; a CDB broadcast in the dispatch
  // cycle is forwarded so the tag is not missed.
  assign cdb_hit1 = i_cdb_valid && (i_cdb_prd != '0) &&
                    (i_cdb_prd == i_disp_prs1) && !i_disp_rdy1;
  assign cdb_hit2 = i_cdb_valid && (i_cdb_prd != '0) &&
                    (i_cdb_prd == i_disp_prs2) && !i_disp_rdy2;

  always_comb begin
    disp_entry             = '0;
    disp_entry.valid       = 1'b1;
    disp_entry.prs1        = i_disp_prs1;
    disp_entry.prs2        = i_disp_prs2;
    disp_entry.rdy1        = i_disp_rdy1 || (i_disp_prs1 == '0) || cdb_hit1;
    disp_entry.rdy2        = i_disp_rdy2 || (i_disp_prs2 == '0) || cdb_hit2;
    disp_entry.bru.alu_op  = i_disp_alu_op;
    disp_entry.bru.pc      = i_disp_pc;
    disp_entry.bru.imm     = i_disp_imm;
    disp_entry.bru.rob_tag = i_disp_rob_tag;
    disp_entry.bru.prd     = i_disp_prd;
    disp_entry.bru.op1     = i_disp_rdy1 ? i_disp_op1 :
                             (cdb_hit1 ? i_cdb_data : '0);
    disp_entry.bru.op2     = i_disp_rdy2 ? i_disp_op2 :
                             (cdb_hit2 ? i_cdb_data : '0);
  end

  // Next entry state: wakeup, then free on issue or squash, then write the
  // dispatch slot (always a free slot, so it never collides with the rest).
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid && i_cdb_valid && (i_cdb_prd != '0)) begin
        if (!entries_q[i].rdy1 && (entries_q[i].prs1 == i_cdb_prd)) begin
          entries_d[i].rdy1    = 1'b1;
          entries_d[i].bru.op1 = i_cdb_data;
        end
        if (!entries_q[i].rdy2 && (entries_q[i].prs2 == i_cdb_prd)) begin
          entries_d[i].rdy2    = 1'b1;
          entries_d[i].bru.op2 = i_cdb_data;
        end
      end
      if (grant_vec[i] || squash_vec[i]) entries_d[i].valid = 1'b0;
    end
    if (disp_fire) entries_d[alloc_idx] = disp_entry;
  end

  // Issue register: data holds when nothing is selected.
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = grant_any;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant_vec[i]) issue_d = entries_q[i].bru;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only the valid bits are reset; payload fields are never read
      // while their valid bit is clear, so they need no reset value.
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i].valid <= 1'b0;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      entries_q     <= entries_d;
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign o_issue_valid   = issue_valid_q;
  assign o_issue_op1     = issue_q.op1;
  assign o_issue_op2     = issue_q.op2;
  assign o_issue_pc      = issue_q.pc;
  assign o_issue_imm     = issue_q.imm;
  assign o_issue_alu_op  = issue_q.alu_op;
  assign o_issue_rob_tag = issue_q.rob_tag;
  assign o_issue_prd     = issue_q.prd;

`ifdef BRANCH_IQ_PERF_EN
  logic [31:0]      perf_issued_q, perf_issued_d;
  logic [31:0]      perf_squashed_q, perf_squashed_d;
  logic [CNT_W-1:0] squash_cnt;
  logic [32:0]      squash_sum;

  always_comb begin
    squash_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      squash_cnt = squash_cnt + CNT_W'(squash_vec[i]);
    end
    squash_sum      = {1'b0, perf_squashed_q} + 33'(squash_cnt);
    perf_squashed_d = squash_sum[32] ? '1 : squash_sum[31:0];
    perf_issued_d   = (grant_any && (perf_issued_q != '1)) ?
                      perf_issued_q + 32'd1 : perf_issued_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q   <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_issued_q   <= perf_issued_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign o_perf_issued   = perf_issued_q;
  assign o_perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_branch_issue_queue.sv
// tb_branch_issue_queue: directed self-checking bench for branch_issue_queue.
// Expected issue bundles are queued in expected issue order as stimulus is
// driven; a negedge monitor pops and compares every issued bundle.
module tb_branch_issue_queue;
  import ooo_pkg::*;

  localparam int DW    = 32;
  localparam int RW    = 4;
  localparam int PW    = 7;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          i_disp_valid;
  logic          o_disp_ready;
  logic [3:0]    i_disp_alu_op;
  logic [DW-1:0] i_disp_pc, i_disp_imm;
  logic [RW-1:0] i_disp_rob_tag;
  logic [PW-1:0] i_disp_prd, i_disp_prs1, i_disp_prs2;
  logic          i_disp_rdy1, i_disp_rdy2;
  logic [DW-1:0] i_disp_op1, i_disp_op2;
  logic          i_cdb_valid;
  logic [PW-1:0] i_cdb_prd;
  logic [DW-1:0] i_cdb_data;
  logic [RW-1:0] i_rob_head;
  logic          i_flush;
  logic [RW-1:0] i_flush_rob_tag;
  logic          o_issue_valid;
  logic [DW-1:0] o_issue_op1, o_issue_op2, o_issue_pc, o_issue_imm;
  logic [3:0]    o_issue_alu_op;
  logic [RW-1:0] o_issue_rob_tag;
  logic [PW-1:0] o_issue_prd;
`ifdef BRANCH_IQ_PERF_EN
  logic [31:0]   o_perf_issued, o_perf_squashed;
`endif

  branch_issue_queue #(
    .DATA_WIDTH (DW),
    .ROB_WIDTH  (RW),
    .PREG_WIDTH (PW),
    .RS_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_disp_valid    (i_disp_valid),
    .o_disp_ready    (o_disp_ready),
    .i_disp_alu_op   (i_disp_alu_op),
    .i_disp_pc       (i_disp_pc),
    .i_disp_imm      (i_disp_imm),
    .i_disp_rob_tag  (i_disp_rob_tag),
    .i_disp_prd      (i_disp_prd),
    .i_disp_prs1     (i_disp_prs1),
    .i_disp_prs2     (i_disp_prs2),
    .i_disp_rdy1     (i_disp_rdy1),
    .i_disp_rdy2     (i_disp_rdy2),
    .i_disp_op1      (i_disp_op1),
    .i_disp_op2      (i_disp_op2),
    .i_cdb_valid     (i_cdb_valid),
    .i_cdb_prd       (i_cdb_prd),
    .i_cdb_data      (i_cdb_data),
    .i_rob_head      (i_rob_head),
    .i_flush         (i_flush),
    .i_flush_rob_tag (i_flush_rob_tag),
    .o_issue_valid   (o_issue_valid),
    .o_issue_op1     (o_issue_op1),
    .o_issue_op2     (o_issue_op2),
    .o_issue_pc      (o_issue_pc),
    .o_issue_imm     (o_issue_imm),
    .o_issue_alu_op  (o_issue_alu_op),
    .o_issue_rob_tag (o_issue_rob_tag),
    .o_issue_prd     (o_issue_prd)
`ifdef BRANCH_IQ_PERF_EN
    ,
    .o_perf_issued   (o_perf_issued),
    .o_perf_squashed (o_perf_squashed)
`endif
  );

  typedef struct {
    logic [RW-1:0] tag;
    logic [3:0]    alu_op;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [PW-1:0] prd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pc_of(input logic [RW-1:0] tag);
    return 32'h1000 + 32'(tag) * 4;
  endfunction

  function automatic logic [DW-1:0] imm_of(input logic [RW-1:0] tag);
    return 32'h40 + 32'(tag);
  endfunction

  task automatic set_disp(input logic [RW-1:0] tag, input logic [3:0] op,
                          input logic [PW-1:0] prs1, input logic rdy1,
                          input logic [DW-1:0] op1,
                          input logic [PW-1:0] prs2, input logic rdy2,
                          input logic [DW-1:0] op2, input logic [PW-1:0] prd);
    i_disp_rob_tag = tag;
    i_disp_alu_op  = op;
    i_disp_prs1    = prs1;
    i_disp_rdy1    = rdy1;
    i_disp_op1     = op1;
    i_disp_prs2    = prs2;
    i_disp_rdy2    = rdy2;
    i_disp_op2     = op2;
    i_disp_prd     = prd;
    i_disp_pc      = pc_of(tag);
    i_disp_imm     = imm_of(tag);
  endtask

  task automatic push_exp(input logic [RW-1:0] tag, input logic [3:0] op,
                          input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                          input logic [PW-1:0] prd);
    exp_t e;
    e.tag    = tag;
    e.alu_op = op;
    e.op1    = op1;
    e.op2    = op2;
    e.pc     = pc_of(tag);
    e.imm    = imm_of(tag);
    e.prd    = prd;
    sb.push_back(e);
  endtask

  task automatic cdb(input logic v, input logic [PW-1:0] prd,
                     input logic [DW-1:0] data);
    i_cdb_valid = v;
    i_cdb_prd   = prd;
    i_cdb_data  = data;
  endtask

  // Scoreboard monitor: every issued bundle must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_issue_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL issue_unexpected: observed tag %0d expected none",
               o_issue_rob_tag);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("issue_tag", o_issue_rob_tag, mon_e.tag);
        check("issue_alu_op", o_issue_alu_op, mon_e.alu_op);
        check("issue_op1", o_issue_op1, mon_e.op1);
        check("issue_op2", o_issue_op2, mon_e.op2);
        check("issue_pc", o_issue_pc, mon_e.pc);
        check("issue_imm", o_issue_imm, mon_e.imm);
        check("issue_prd", o_issue_prd, mon_e.prd);
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    i_disp_valid    = 1'b0;
    i_flush         = 1'b0;
    i_flush_rob_tag = '0;
    i_rob_head      = '0;
    cdb(1'b0, '0, '0);
    set_disp('0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);

    // Reset state.
    repeat (2) tick();
    check("rst_issue_valid", o_issue_valid, 0);
    check("rst_issue_tag", o_issue_rob_tag, 0);
    check("rst_issue_op1", o_issue_op1, 0);
    check("rst_issue_pc", o_issue_pc, 0);
    check("rst_disp_ready", o_disp_ready, 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", o_disp_ready, 1);

    // Ready BEQ issues one cycle after it enters the queue.
    set_disp(4'd3, 4'b0000, 7'd1, 1'b1, 32'd5, 7'd2, 1'b1, 32'd5, 7'd0);
    push_exp(4'd3, 4'b0000, 32'd5, 32'd5, 7'd0);
    i_disp_valid = 1'b1;
    tick();
    i_disp_valid = 1'b0;
    check("t1_not_yet", o_issue_valid, 0);
    check("t1_ready", o_disp_ready, 1);
    tick();
    check("t1_issue_valid", o_issue_valid, 1);
    check("t1_issue_tag", o_issue_rob_tag, 3);
    check("t1_ready_after", o_disp_ready, 1);
    tick();
    check("t1_issue_drop", o_issue_valid, 0);

    // Wakeup through the CDB two cycles after dispatch; prs2=0 reads zero.
    set_disp(4'd2, 4'b0001, 7'd9, 1'b0, 32'd0, 7'd0, 1'b0, 32'hdead, 7'd0);
    push_exp(4'd2, 4'b0001, 32'h40, 32'd0, 7'd0);
    i_disp_valid = 1'b1;
    tick();
    i_disp_valid = 1'b0;
    tick();
    cdb(1'b1, 7'd9, 32'h40);
    tick();
    cdb(1'b0, '0, '0);
    check("t2_wait", o_issue_valid, 0);
    tick();
    check("t2_issue_valid", o_issue_valid, 1);
    check("t2_issue_op1", o_issue_op1, 32'h40);
    tick();

    // Wrap-around age: head 14, issue order 14, 15, 1.
    i_rob_head = 4'd14;
    i_disp_valid = 1'b1;
    set_disp(4'd1, ALU_JALR, 7'd20, 1'b0, '0, 7'd0, 1'b1, '0, 7'd5);
    tick();
    set_disp(4'd15, ALU_JAL, 7'd20, 1'b0, '0, 7'd0, 1'b1, '0, 7'd6);
    tick();
    set_disp(4'd14, 4'b0101, 7'd20, 1'b0, '0, 7'd0, 1'b1, '0, 7'd0);
    tick();
    i_disp_valid = 1'b0;
    push_exp(4'd14, 4'b0101, 32'h11, 32'd0, 7'd0);
    push_exp(4'd15, ALU_JAL, 32'h11, 32'd0, 7'd6);
    push_exp(4'd1, ALU_JALR, 32'h11, 32'd0, 7'd5);
    cdb(1'b1, 7'd20, 32'h11);
    tick();
    cdb(1'b0, '0, '0);
    tick();
    check("t3_first", o_issue_rob_tag, 14);
    tick();
    check("t3_second", o_issue_rob_tag, 15);
    tick();
    check("t3_third", o_issue_rob_tag, 1);
    tick();
    check("t3_idle", o_issue_valid, 0);

    // Fill all slots with waiting ops; further dispatch is held.
    i_rob_head = 4'd0;
    i_disp_valid = 1'b1;
    for (int t = 4; t < 8; t++) begin
      set_disp(RW'(t), 4'b0100, PW'(26 + t), 1'b0, '0, 7'd0, 1'b1,
               32'(t), 7'd0);
      tick();
    end
    check("t4_full", o_disp_ready, 0);
    set_disp(4'd9, 4'b0110, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd2, 7'd3);
    tick();
    check("t4_held", o_disp_ready, 0);
    push_exp(4'd4, 4'b0100, 32'ha, 32'd4, 7'd0);
    push_exp(4'd9, 4'b0110, 32'd1, 32'd2, 7'd3);
    cdb(1'b1, 7'd30, 32'ha);
    tick();
    cdb(1'b0, '0, '0);
    check("t4_ready_low_at_wake", o_disp_ready, 0);
    tick();
    check("t4_issue_tag4", o_issue_rob_tag, 4);
    check("t4_ready_back", o_disp_ready, 1);
    tick();
    i_disp_valid = 1'b0;
    check("t4_refilled", o_disp_ready, 0);
    tick();
    check("t4_issue_tag9", o_issue_rob_tag, 9);
    check("t4_ready_after", o_disp_ready, 1);

    // Flush at tag 5 with head 4: tags 6, 7 squashed, tag 8 dispatch dropped.
    i_rob_head      = 4'd4;
    i_flush         = 1'b1;
    i_flush_rob_tag = 4'd5;
    set_disp(4'd8, 4'b0000, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1, 7'd0);
    i_disp_valid = 1'b1;
    tick();
    i_flush      = 1'b0;
    i_disp_valid = 1'b0;
    check("t5_ready", o_disp_ready, 1);
    check("t5_no_issue", o_issue_valid, 0);
    cdb(1'b1, 7'd32, 32'hbad);
    tick();
    cdb(1'b1, 7'd33, 32'hbad);
    tick();
    cdb(1'b0, '0, '0);
    check("t5_sq6_silent", o_issue_valid, 0);
    tick();
    check("t5_sq7_silent", o_issue_valid, 0);
    push_exp(4'd5, 4'b0100, 32'hb, 32'd5, 7'd0);
    cdb(1'b1, 7'd31, 32'hb);
    tick();
    cdb(1'b0, '0, '0);
    tick();
    check("t5_survivor", o_issue_rob_tag, 5);
    check("t5_survivor_valid", o_issue_valid, 1);
    tick();

    // Same-cycle CDB forwarding into the dispatching entry.
    set_disp(4'd10, 4'b0111, 7'd0, 1'b1, 32'd3, 7'd12, 1'b0, 32'd0, 7'd0);
    push_exp(4'd10, 4'b0111, 32'd3, 32'd7, 7'd0);
    cdb(1'b1, 7'd12, 32'd7);
    i_disp_valid = 1'b1;
    tick();
    i_disp_valid = 1'b0;
    cdb(1'b0, '0, '0);
    check("t6_not_yet", o_issue_valid, 0);
    tick();
    check("t6_issue_valid", o_issue_valid, 1);
    check("t6_issue_op2", o_issue_op2, 32'd7);
    tick();

    // Reset mid-operation discards waiting entries and a pending issue.
    i_disp_valid = 1'b1;
    set_disp(4'd11, 4'b0000, 7'd40, 1'b0, '0, 7'd0, 1'b1, '0, 7'd0);
    tick();
    set_disp(4'd12, 4'b0000, 7'd0, 1'b1, 32'd9, 7'd0, 1'b1, 32'd9, 7'd0);
    tick();
    i_disp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t7_rst_valid", o_issue_valid, 0);
    check("t7_rst_tag", o_issue_rob_tag, 0);
    check("t7_rst_op2", o_issue_op2, 0);
    check("t7_rst_ready", o_disp_ready, 1);
    rst_n = 1'b1;
    cdb(1'b1, 7'd40, 32'h5);
    tick();
    cdb(1'b0, '0, '0);
    tick();
    check("t7_no_issue", o_issue_valid, 0);
    tick();
    check("t7_no_issue_late", o_issue_valid, 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
